// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder (serial_adder_ctrl).
// Optional overflow output is enabled by defining SERIAL_ADD_OVF_EN.
package serial_adder_pkg;

   localparam int SA_WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } sa_state_e;

   // Counter must hold 0..WIDTH without wrapping.
   function automatic int sa_cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// Single-bit full-adder cell used by serial_adder_ctrl, one bit per cycle.
// Purely combinational.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic w_axb;

   assign w_axb = a ^ b;
   assign s     = w_axb ^ cin;
   assign cout  = (a & b) | (cin & w_axb);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: latches A/B/Cin on start, adds LSB-first over WIDTH cycles.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = SA_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             Carry
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = sa_cnt_width(WIDTH);

   sa_state_e          r_state;
   sa_state_e          w_state_nxt;
   logic               w_load;
   logic               w_step;
   logic               w_last;

   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:1]   r_res;
   logic               r_carry;
   logic [CNT_W-1:0]   r_cnt;

   logic               w_s;
   logic               w_cout;
   logic [WIDTH-1:0]   w_res_nxt;

   fa_cell u_fa (
      .a    (r_a[0]),
      .b    (r_b[0]),
      .cin  (r_carry),
      .s    (w_s),
      .cout (w_cout)
   );

   assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_res_nxt = {w_s, r_res};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      w_load      = 1'b0;
      w_step      = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            busy   = 1'b1;
            w_step = 1'b1;
            if (w_last) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = RUN;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Operand and partial-result shift registers carry no reset; they are
   // always reloaded or fully overwritten before being observed.
   always_ff @(posedge clk) begin
      if (w_load) begin
         r_a <= A;
         r_b <= B;
      end else if (w_step) begin
         r_a   <= r_a >> 1;
         r_b   <= r_b >> 1;
         r_res <= w_res_nxt[WIDTH-1:1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_carry <= 1'b0;
      end else if (w_load) begin
         r_cnt   <= '0;
         r_carry <= Cin;
      end else if (w_step) begin
         r_carry <= w_cout;
         if (!w_last) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   // Visible results change only on the final bit-cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         Sum   <= '0;
         Carry <= 1'b0;
      end else if (w_step && w_last) begin
         Sum   <= w_res_nxt;
         Carry <= w_cout;
      end
   end

`ifdef SERIAL_ADD_OVF_EN
   // On the last cycle r_carry is the carry into the MSB.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf <= 1'b0;
      end else if (w_step && w_last) begin
         ovf <= r_carry ^ w_cout;
      end
   end
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed cases plus randomized traffic
// against a timeline/arithmetic reference model. Honours SERIAL_ADD_OVF_EN.
module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Cin;
   logic         busy;
   logic         done;
   logic [W-1:0] Sum;
   logic         Carry;
`ifdef SERIAL_ADD_OVF_EN
   logic         ovf;
`endif

   int n_chk = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .Cin   (Cin),
      .busy  (busy),
      .done  (done),
      .Sum   (Sum),
      .Carry (Carry)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h", nm, got, exp);
      end
   endtask

   // {signed overflow, carry, sum} from plain arithmetic
   function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic c);
      logic [W:0] tot;
      logic       o;
      tot = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      o   = (a[W-1] == b[W-1]) && (tot[W-1] != a[W-1]);
      return {o, tot};
   endfunction

   // Reference timeline: an accepted start at edge e produces busy after edges
   // e..e+W-1, done after edge e+W, and results published at edge e+W.
   int           edge_n = 0;
   bit           m_act  = 1'b0;
   int           m_end  = 0;
   logic [W-1:0] p_sum, m_sum;
   logic         p_c, m_c, p_o, m_o;

   always @(posedge clk) begin
      if (rst) begin
         m_act <= 1'b0;
         m_sum <= '0;
         m_c   <= 1'b0;
         m_o   <= 1'b0;
      end else begin
         if (m_act && edge_n == m_end) begin
            m_sum <= p_sum;
            m_c   <= p_c;
            m_o   <= p_o;
         end
         if (start && !(m_act && edge_n <= m_end)) begin
            m_act               <= 1'b1;
            m_end               <= edge_n + W;
            {p_o, p_c, p_sum}   <= ref_add(A, B, Cin);
         end
      end
      edge_n <= edge_n + 1;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_busy",  busy,  m_act && (edge_n - 1) <  m_end);
         chk("m_done",  done,  m_act && (edge_n - 1) == m_end);
         chk("m_sum",   Sum,   m_sum);
         chk("m_carry", Carry, m_c);
`ifdef SERIAL_ADD_OVF_EN
         chk("m_ovf",   ovf,   m_o);
`endif
      end
   end

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      @(posedge clk);
      #1;
      A = a; B = b; Cin = c; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Waits for done; c0 = cycles since the start edge already consumed.
   task automatic wait_done(input string nm, input int c0, input logic [W-1:0] es,
                            input logic ec);
      int           cyc  = c0;
      bit           seen = 1'b0;
      bit           held = 1'b1;
      logic [W-1:0] hold = Sum;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (Sum !== hold) held = 1'b0;
      end
      if (!seen) begin
         n_chk++;
         n_bad++;
         $display("FAIL %s_timeout: got=no done want=done within 30 cycles", nm);
      end else begin
         chk({nm, "_lat"},   cyc,   W + 1);
         chk({nm, "_sum"},   Sum,   es);
         chk({nm, "_carry"}, Carry, ec);
      end
      chk({nm, "_hold"}, held, 1);
   endtask

   task automatic no_done(input string nm, input int n);
      bit any = 1'b0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (done) any = 1'b1;
      end
      chk(nm, any, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst    = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_busy",  busy,  0);
      chk("rst_done",  done,  0);
      chk("rst_sum",   Sum,   0);
      chk("rst_carry", Carry, 0);

      start_op(8'h0F, 8'h01, 1'b0);
      wait_done("basic", 0, 8'h10, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
      chk("basic_ovf", ovf, 0);
`endif
      start_op(8'hFF, 8'h01, 1'b0);
      wait_done("cout1", 0, 8'h00, 1'b1);
`ifdef SERIAL_ADD_OVF_EN
      chk("cout1_ovf", ovf, 0);
`endif
      start_op(8'hFF, 8'h00, 1'b1);
      wait_done("cin", 0, 8'h00, 1'b1);

      start_op(8'h7F, 8'h01, 1'b0);
      wait_done("ovfpos", 0, 8'h80, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
      chk("ovfpos_ovf", ovf, 1);
`endif
      start_op(8'h80, 8'h80, 1'b0);
      wait_done("ovfneg", 0, 8'h00, 1'b1);
`ifdef SERIAL_ADD_OVF_EN
      chk("ovfneg_ovf", ovf, 1);
`endif

      // second request lands on the 3rd busy cycle and must be dropped
      start_op(8'h10, 8'h20, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      A = 8'h55; B = 8'h55; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("busyrej", 3, 8'h30, 1'b0);
      no_done("busyrej_single", 12);

      // reset sampled on the 4th busy cycle
      start_op(8'hAA, 8'h55, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_busy",  busy,  0);
      chk("abort_sum",   Sum,   0);
      chk("abort_carry", Carry, 0);
      no_done("abort_nodone", 12);
      start_op(8'h01, 8'h02, 1'b0);
      wait_done("after_rst", 0, 8'h03, 1'b0);

      // back-to-back: new start raised during the done cycle
      start_op(8'h01, 8'h01, 1'b0);
      wait_done("b2b_first", 0, 8'h02, 1'b0);
      A = 8'h02; B = 8'h03; Cin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("b2b_second", 0, 8'h05, 1'b0);

      for (int i = 0; i < 600; i++) begin
         @(posedge clk);
         #1;
         rst   = ($urandom_range(0, 80) == 0);
         start = ($urandom_range(0, 2) == 0);
         A     = W'($urandom);
         B     = W'($urandom);
         Cin   = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      rst = 1'b0; start = 1'b0;
      repeat (W + 4) @(posedge clk);
      @(negedge clk);
      chk_en = 1'b0;

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand/sum width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to begin an addition; sampled on rising edge of clk.
REQ-005 A  input  WIDTH  operand A; captured only when start is accepted.
REQ-006 B  input  WIDTH  operand B; captured only when start is accepted.
REQ-007 Cin  input  1  carry-in; captured only when start is accepted.
REQ-008 busy  output  1  high while bits are being processed.
REQ-009 done  output  1  one-cycle pulse when Sum/Carry become valid.
REQ-010 Sum  output  WIDTH  result; held stable from done until the next accepted start.
REQ-011 Carry  output  1  final carry-out; same hold rule as Sum.
REQ-012 ovf  output  1  signed overflow; present only under SERIAL_ADD_OVF_EN.

Function
REQ-013 FSM states: IDLE, RUN, DONE.
- IDLE->RUN on start.
- RUN->DONE after WIDTH bit-cycles.
- DONE->RUN on start; otherwise DONE->IDLE.
REQ-014 Start is accepted in IDLE or DONE. On acceptance, A, B and Cin are latched into shift registers, bit counter cleared to 0, carry flop loaded with Cin.
REQ-015 start is ignored while in RUN; busy=1 signals this, and latched operands are unaffected.
REQ-016 RUN processes one bit per cycle, LSB first, through one full-adder cell:
- cell inputs: A_sh[0], B_sh[0], carry flop.
- cell sum bit shifts into the MSB of the result register.
- cell carry-out reloads the carry flop.
- both operand registers shift right by 1.
REQ-017 Bit counter is $clog2(WIDTH+1) bits wide; RUN exits when the counter reaches WIDTH-1 on a processing cycle, with no wrap-around.
REQ-018 Timing: start accepted at edge t, busy=1 for edges t+1..t+WIDTH, done=1 and Sum/Carry valid for the cycle after edge t+WIDTH. Latency is WIDTH+1 cycles from the start edge to done.
REQ-019 Sum and Carry update only at the RUN->DONE transition (internal result register copied to outputs), never mid-operation.
REQ-020 done is high only in DONE and lasts exactly one cycle; busy and done are never high together.
REQ-021 Back-to-back: start high during the done cycle is accepted, and the new busy period begins the next cycle; Sum/Carry keep the old result until the new done.

Reset
REQ-022 rst high at a rising edge forces IDLE, busy=0, done=0, Sum=0, Carry=0, ovf=0, counter=0 and carry flop=0, overriding start.
REQ-023 Reset mid-RUN aborts the operation with no done pulse; the first start after rst deasserts is accepted normally.

Configuration
REQ-024 With SERIAL_ADD_OVF_EN defined, ovf is a port and is registered at RUN->DONE as the carry into the MSB XOR the final carry-out, with the same hold rule as Sum.
REQ-025 Without SERIAL_ADD_OVF_EN, the ovf port and its logic are absent; all other behaviour is unchanged.

Structure
REQ-026 Shared package serial_adder_pkg holds the FSM state typedef (IDLE/RUN/DONE, 2-bit encoding) and the WIDTH default constant.
REQ-027 The single-bit datapath is one sub-module, fa_cell (ports a, b, cin, s, cout; purely combinational); serial_adder_ctrl instantiates it exactly once.

Verification
REQ-028 Basic: WIDTH=8, A=0x0F, B=0x01, Cin=0, start pulse -> done exactly 9 cycles after the start edge, Sum=0x10, Carry=0, ovf=0.
REQ-029 Carry-out: A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Carry=1, ovf=0; A=0xFF, B=0x00, Cin=1 -> Sum=0x00, Carry=1.
REQ-030 Overflow (macro on): A=0x7F, B=0x01 -> Sum=0x80, Carry=0, ovf=1; A=0x80, B=0x80 -> Sum=0x00, Carry=1, ovf=1.
REQ-031 Busy rejection: start with 0x10+0x20, then start with 0x55+0x55 on the 3rd busy cycle -> single done, Sum=0x30; the second request is lost.
REQ-032 Reset mid-run: start 0xAA+0x55, rst on the 4th busy cycle -> no done pulse, all outputs 0; next start 0x01+0x02 -> Sum=0x03 after 9 cycles.
REQ-033 Back-to-back: start 0x01+0x01, then start 0x02+0x03 during the done cycle -> done pulses 9 cycles apart, Sum=0x02 then Sum=0x05, Sum stable between the pulses.
